segments2data: RTL and testbench
================================

Name: segments2data

Overview:
- Decoder for the multiplexed 7-segment bus produced by the team's display driver.
- Samples Indicators/Segments, recovers the digit per scan slot, decodes segment codes back to BCD, and reassembles the binary Data word.
- Sign-magnitude encoding when Signed="Yes".
- Used for board-to-board loopback checks and display-bus monitoring.

Parameters:
- Size, 4, width of recovered Data.
- Signed, "Yes", "Yes": MSD slot carries sign (Empty/Minus) and Data is sign-magnitude; "No": all slots are magnitude digits.
- ClockPeriod_ns, 20, local clock period.
- RefreshTime_ns, 20_000, full scan period of the observed display.
- SettleCycles, 4, clocks a sampled Indicators/Segments pair must stay unchanged before it is accepted.
- ISize (localparam), the same digit count as the display driver:
  - Signed="No": General::clog10(1<<Size).
  - Signed="Yes": General::clog10(1<<(Size-1))+1.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Indicators  input  ISize  digit select, active-low one-hot, bit k = slot k (slot 0 = least significant digit).
- Segments  input  8  segment code as produced by General::BCD2ESC.
- Data  output  Size  recovered value.
- Valid  output  1  one-clock pulse: Data updated with a good frame.
- Error  output  1  one-clock pulse: frame rejected, Data unchanged.

Behaviour:
- Reset (async, active-high): Data=0, Valid=0, Error=0, slot registers=0, seen mask=0, state COLLECT, settle and timeout counters=0.
- Settle filter:
  - Counter clears whenever {Indicators,Segments} differs from the previous cycle; otherwise increments, saturating.
  - The pair is accepted once, in the cycle the counter reaches SettleCycles-1.
- Accepted pair handling:
  - Indicators not exactly one zero (all-ones, or multiple zeros): ignored.
  - Otherwise the slot is the index of the zero bit. General::ESC2BCD(Segments) is stored in that slot and its seen bit is set.
  - Re-seeing a slot overwrites it (last value wins).
- States:
  - COLLECT: waits until the seen mask is all ones → CONVERT. The mask is cleared on entry to CONVERT.
  - CONVERT: accumulator = acc*10 + digit, one digit per clock, MSD first. Covers ISize-1 magnitude digits if Signed="Yes", else ISize digits. Accumulator is wide enough to hold 10^digits-1.
  - PUBLISH: one cycle. Asserts Valid or Error, then → COLLECT.
- Digit rules:
  - Empty in a magnitude slot counts as 0.
  - Any undecodable code, or Minus in a magnitude slot: frame error.
  - Signed sign slot: only Empty (sign 0) or Minus (sign 1) is legal; a digit 0-9 there is a frame error.
- Range rules:
  - Unsigned: magnitude > 2^Size-1 → error.
  - Signed: magnitude > 2^(Size-1)-1 → error.
  - On success, Data = {sign, magnitude[Size-2:0]} (signed) or magnitude (unsigned).
- Latency: the PUBLISH pulse follows the final accepted slot by (digits+2) clocks.
- Timeout: in COLLECT, if no pair is accepted for 2*RefreshTime_ns/ClockPeriod_ns clocks, the seen mask clears with no pulse.
- Pairs accepted during CONVERT/PUBLISH are stored and count toward the next frame.
- Valid and Error are never asserted together.

Optional Feature:
- SEGMENTS2DATA_SYNC_EN defined: Indicators and Segments each pass a 2-flop synchronizer, reset to all-ones, before the settle filter. Adds 2 clocks latency.
- Undefined: inputs feed the settle filter directly; same-clock-domain loopback only.

Decomposition:
- General package gains:
  - ESC2BCD(input bit [7:0]) returning a 4-bit code plus a legal flag; exact inverse of BCD2ESC, including Empty and Minus.
  - The existing Empty/Minus constants, reused.
  - A typedef enum {COLLECT, CONVERT, PUBLISH} for the state.
- One sub-module, SettleFilter #(Width, N): outputs an accept pulse and the held value; also reusable for key debouncing.

Test Plan:
- Size=4 Signed="Yes", slot1=Minus, slot0='5', each held 1000 clocks → Data=4'hD, single Valid pulse, Error=0.
- Size=8 Signed="No", slots='2','5','5' → Data=8'hFF, Valid; then slots='3','0','0' → Error pulse, Data stays 8'hFF.
- Size=4 Signed="Yes", slot1=Empty, slot0='9' → Error (9>7); slot1='3' (digit in sign slot) → Error.
- Glitch: Segments toggled for SettleCycles-1 clocks between slots → no accept, no change in Data; Indicators=2'b00 held → ignored.
- Only slot0 driven for 3*RefreshTime → no pulse; then a full frame → exactly one Valid with the correct value.
- Reset asserted mid-CONVERT → outputs 0 immediately; no pulse after release until a new full frame is collected.

Source files
------------

// File: rtl/segments2data_pkg.sv
// segments2data_pkg: state type, BCD/segment code tables and the constant helpers used to
// size the segment-bus decoder.
package segments2data_pkg;

   typedef enum logic [1:0] {COLLECT, CONVERT, PUBLISH} state_e;

   // Non-digit BCD codes carried alongside 0-9
   localparam logic [3:0] Empty = 4'hA;
   localparam logic [3:0] Minus = 4'hB;
   localparam logic [3:0] Bad   = 4'hF;

   // Segment codes, bit order {dp, g, f, e, d, c, b, a}, active-high, dp never lit
   localparam logic [7:0] EscEmpty = 8'h00;
   localparam logic [7:0] EscMinus = 8'h40;

   typedef struct packed {
      logic       legal;
      logic [3:0] code;
   } esc_dec_t;

   function automatic logic [7:0] bcd2esc(input logic [3:0] bcd);
      logic [7:0] esc;
      case (bcd)
         4'd0:    esc = 8'h3F;
         4'd1:    esc = 8'h06;
         4'd2:    esc = 8'h5B;
         4'd3:    esc = 8'h4F;
         4'd4:    esc = 8'h66;
         4'd5:    esc = 8'h6D;
         4'd6:    esc = 8'h7D;
         4'd7:    esc = 8'h07;
         4'd8:    esc = 8'h7F;
         4'd9:    esc = 8'h6F;
         Minus:   esc = EscMinus;
         default: esc = EscEmpty;
      endcase
      return esc;
   endfunction

   // Inverse of bcd2esc; anything bcd2esc cannot produce comes back as Bad, not legal
   function automatic esc_dec_t esc2bcd(input logic [7:0] esc);
      esc_dec_t r;
      r.legal = 1'b1;
      r.code  = Bad;
      case (esc)
         8'h3F:    r.code = 4'd0;
         8'h06:    r.code = 4'd1;
         8'h5B:    r.code = 4'd2;
         8'h4F:    r.code = 4'd3;
         8'h66:    r.code = 4'd4;
         8'h6D:    r.code = 4'd5;
         8'h7D:    r.code = 4'd6;
         8'h07:    r.code = 4'd7;
         8'h7F:    r.code = 4'd8;
         8'h6F:    r.code = 4'd9;
         EscEmpty: r.code = Empty;
         EscMinus: r.code = Minus;
         default:  r.legal = 1'b0;
      endcase
      return r;
   endfunction

   // Decimal digits needed to show every value below n
   function automatic int unsigned clog10(input longint unsigned n);
      longint unsigned p;
      int unsigned     d;
      p = 1;
      d = 0;
      while (p < n) begin
         p = p * 10;
         d = d + 1;
      end
      return d;
   endfunction

   function automatic longint unsigned pow10(input int unsigned d);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/segments2data_if.sv
// segments2data_if: observed display bus (Indicators/Segments) plus recovered-value outputs.
interface segments2data_if #(
   parameter int unsigned ISize = 2,
   parameter int unsigned Size  = 4
);
   logic [ISize-1:0] Indicators;
   logic [7:0]       Segments;
   logic [Size-1:0]  Data;
   logic             Valid;
   logic             Error;

   modport master (output Indicators, Segments, input Data, Valid, Error);
   modport slave  (input Indicators, Segments, output Data, Valid, Error);
endinterface

// File: rtl/segments2data_settle_filter.sv
// segments2data_settle_filter: accepts a value once after it has been stable for N clocks.
// Emits a single accept pulse with the held value; usable for key debouncing too. N >= 2.
module segments2data_settle_filter #(
   parameter int unsigned Width = 8,
   parameter int unsigned N     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] din,
   output logic             accept,
   output logic [Width-1:0] value
);
   localparam int unsigned CntWidth = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(N - 1);

   logic [Width-1:0]    prev_q, value_q;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                accept_q, accept_d, same;

   // Saturating stability counter; the accept fires only on the step into CntMax
   always_comb begin
      same     = (din == prev_q);
      cnt_d    = '0;
      accept_d = 1'b0;
      if (same) begin
         cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
         accept_d = (cnt_q == CntMax - 1'b1);
      end
   end

   // History, counter and held-value registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q   <= '0;
         cnt_q    <= '0;
         accept_q <= 1'b0;
         value_q  <= '0;
      end else begin
         prev_q   <= din;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
         if (accept_d) value_q <= prev_q;
      end
   end

   assign accept = accept_q;
   assign value  = value_q;
endmodule

// File: rtl/segments2data.sv
// segments2data: decodes a multiplexed 7-segment bus back into a binary (or sign-magnitude)
// word. Define SEGMENTS2DATA_SYNC_EN to put 2-flop synchronizers on Indicators/Segments.
module segments2data
   import segments2data_pkg::*;
#(
   parameter int unsigned Size           = 4,
   parameter string       Signed         = "Yes",
   parameter int unsigned ClockPeriod_ns = 20,
   parameter int unsigned RefreshTime_ns = 20_000,
   parameter int unsigned SettleCycles   = 4
) (
   input logic            Clock,
   input logic            Reset,
   segments2data_if.slave bus
);
   localparam bit IsSigned = (Signed == "Yes");
   localparam int unsigned ISize = IsSigned ? clog10(64'd1 << (Size - 1)) + 1
                                            : clog10(64'd1 << Size);
   localparam int unsigned MagDigits = IsSigned ? ISize - 1 : ISize;
   localparam int unsigned MagBits   = IsSigned ? Size - 1 : Size;
   localparam int unsigned AccWidth  = $clog2(pow10(MagDigits));
   localparam logic [AccWidth-1:0] MaxMag = AccWidth'((64'd1 << MagBits) - 64'd1);
   localparam int unsigned TimeoutCycles = 2 * RefreshTime_ns / ClockPeriod_ns;
   localparam int unsigned ToWidth  = $clog2(TimeoutCycles + 1);
   localparam int unsigned IdxWidth = (ISize > 1) ? $clog2(ISize) : 1;
   localparam logic [IdxWidth-1:0] FirstIdx = IdxWidth'(MagDigits - 1);

   logic [ISize-1:0] ind_in;
   logic [7:0]       seg_in;

`ifdef SEGMENTS2DATA_SYNC_EN
   logic [ISize-1:0] ind_s1, ind_s2;
   logic [7:0]       seg_s1, seg_s2;

   // Two-flop synchronizers, idle (all ones) out of reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ind_s1 <= '1;
         ind_s2 <= '1;
         seg_s1 <= '1;
         seg_s2 <= '1;
      end else begin
         ind_s1 <= bus.Indicators;
         ind_s2 <= ind_s1;
         seg_s1 <= bus.Segments;
         seg_s2 <= seg_s1;
      end
   end

   assign ind_in = ind_s2;
   assign seg_in = seg_s2;
`else
   assign ind_in = bus.Indicators;
   assign seg_in = bus.Segments;
`endif

   logic             accept;
   logic [ISize-1:0] acc_ind;
   logic [7:0]       acc_seg;

   segments2data_settle_filter #(
      .Width (ISize + 8),
      .N     (SettleCycles)
   ) u_settle (
      .clk    (Clock),
      .rst    (Reset),
      .din    ({ind_in, seg_in}),
      .accept (accept),
      .value  ({acc_ind, acc_seg})
   );

   state_e                  state_q, state_d;
   logic [ISize-1:0]        seen_q, seen_d;
   logic [ISize-1:0][3:0]   slots_q, slots_d, frame_q, frame_d;
   logic [AccWidth-1:0]     acc_q, acc_d, acc_next;
   logic [IdxWidth-1:0]     idx_q, idx_d, slot_idx;
   logic [ToWidth-1:0]      to_q, to_d;
   logic                    bad_q, bad_d, sign_q, sign_d;
   logic [Size-1:0]         data_q, data_d;
   logic                    valid_q, valid_d, error_q, error_d;
   logic                    slot_ok, digit_bad;
   logic [3:0]              digit_code, digit_val;
   esc_dec_t                dec;

   // Slot select decode: exactly one active-low indicator picks the slot
   always_comb begin
      slot_ok  = $onehot(~acc_ind);
      slot_idx = '0;
      for (int k = 0; k < ISize; k++) begin
         if (!acc_ind[k]) slot_idx = IdxWidth'(k);
      end
      dec = esc2bcd(acc_seg);
   end

   // Frame FSM: collect slots, convert MSD-first, publish one result pulse
   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      slots_d = slots_q;
      frame_d = frame_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      to_d    = to_q;
      bad_d   = bad_q;
      sign_d  = sign_q;
      data_d  = data_q;
      valid_d = 1'b0;
      error_d = 1'b0;

      digit_code = frame_q[idx_q];
      digit_bad  = (digit_code > 4'd9) && (digit_code != Empty);
      digit_val  = (digit_code == Empty) ? 4'd0 : digit_code;
      acc_next   = acc_q * AccWidth'(10) + AccWidth'(digit_val);

      case (state_q)
         COLLECT: begin
            if (accept) begin
               to_d = '0;
            end else if (to_q == ToWidth'(TimeoutCycles - 1)) begin
               to_d   = '0;
               seen_d = '0;
            end else begin
               to_d = to_q + 1'b1;
            end
            if (&seen_q) begin
               // Snapshot so slots arriving during conversion go to the next frame
               state_d = CONVERT;
               seen_d  = '0;
               frame_d = slots_q;
               acc_d   = '0;
               idx_d   = FirstIdx;
               to_d    = '0;
               if (IsSigned) begin
                  sign_d = (slots_q[ISize-1] == Minus);
                  bad_d  = !((slots_q[ISize-1] == Empty) || (slots_q[ISize-1] == Minus));
               end else begin
                  sign_d = 1'b0;
                  bad_d  = 1'b0;
               end
            end
         end
         CONVERT: begin
            acc_d = acc_next;
            if (idx_q == '0) begin
               state_d = PUBLISH;
               if (bad_q || digit_bad || (acc_next > MaxMag)) begin
                  error_d = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  data_d  = IsSigned ? {sign_q, acc_next[Size-2:0]} : acc_next[Size-1:0];
               end
            end else begin
               idx_d = idx_q - 1'b1;
               bad_d = bad_q | digit_bad;
            end
         end
         PUBLISH: state_d = COLLECT;
         default: state_d = COLLECT;
      endcase

      // Accepted pairs are stored in every state; last value wins
      if (accept && slot_ok) begin
         slots_d[slot_idx] = dec.legal ? dec.code : Bad;
         seen_d[slot_idx]  = 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= COLLECT;
         seen_q  <= '0;
         slots_q <= '0;
         frame_q <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         to_q    <= '0;
         bad_q   <= 1'b0;
         sign_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
         slots_q <= slots_d;
         frame_q <= frame_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         to_q    <= to_d;
         bad_q   <= bad_d;
         sign_q  <= sign_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign bus.Data  = data_q;
   assign bus.Valid = valid_q;
   assign bus.Error = error_q;
endmodule

// File: tb/tb_segments2data.sv
// tb_segments2data: directed checks of a signed 4-bit and an unsigned 8-bit decoder.
module tb_segments2data;

`ifdef SEGMENTS2DATA_SYNC_EN
   localparam int SyncLat = 2;
`else
   localparam int SyncLat = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   segments2data_if #(.ISize(2), .Size(4)) bus_s ();
   segments2data_if #(.ISize(3), .Size(8)) bus_u ();

   segments2data #(.Size(4), .Signed("Yes")) u_dut_s (.Clock(clk), .Reset(rst), .bus(bus_s));
   segments2data #(.Size(8), .Signed("No"))  u_dut_u (.Clock(clk), .Reset(rst), .bus(bus_u));

   int tests_run = 0;
   int tests_failed = 0;
   int vs = 0, es = 0, vu = 0, eu = 0, both = 0;

   // Pulse counters
   always @(posedge clk) begin
      if (bus_s.Valid) vs <= vs + 1;
      if (bus_s.Error) es <= es + 1;
      if (bus_u.Valid) vu <= vu + 1;
      if (bus_u.Error) eu <= eu + 1;
      if ((bus_s.Valid && bus_s.Error) || (bus_u.Valid && bus_u.Error)) both <= both + 1;
   end

   // 10 = blank, 11 = minus
   function automatic logic [7:0] seg(input int d);
      case (d)
         0: return 8'h3F;   1: return 8'h06;   2: return 8'h5B;   3: return 8'h4F;
         4: return 8'h66;   5: return 8'h6D;   6: return 8'h7D;   7: return 8'h07;
         8: return 8'h7F;   9: return 8'h6F;   10: return 8'h00;  default: return 8'h40;
      endcase
   endfunction

   task automatic hold_s(input logic [1:0] ind, input logic [7:0] sg, input int n);
      bus_s.Indicators = ind;
      bus_s.Segments   = sg;
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_u(input logic [2:0] ind, input logic [7:0] sg, input int n);
      bus_u.Indicators = ind;
      bus_u.Segments   = sg;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      bus_s.Indicators = 2'b11;
      bus_s.Segments   = 8'h00;
      bus_u.Indicators = 3'b111;
      bus_u.Segments   = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus_s.Data !== 4'h0) begin
         tests_failed++; $display("FAIL reset_data_s: got %h want 0", bus_s.Data);
      end
      tests_run++;
      if (bus_s.Valid !== 1'b0 || bus_s.Error !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags_s: got %b%b want 00", bus_s.Valid, bus_s.Error);
      end
      tests_run++;
      if (bus_u.Data !== 8'h00) begin
         tests_failed++; $display("FAIL reset_data_u: got %h want 00", bus_u.Data);
      end
      tests_run++;
      if (bus_u.Valid !== 1'b0 || bus_u.Error !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags_u: got %b%b want 00", bus_u.Valid, bus_u.Error);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_signed_minus();
      int v0 = vs, e0 = es;
      hold_s(2'b01, seg(11), 1000);
      hold_s(2'b10, seg(5), 1000);
      tests_run++;
      if (bus_s.Data !== 4'hD) begin
         tests_failed++; $display("FAIL minus5_data: got %h want d", bus_s.Data);
      end
      tests_run++;
      if (vs - v0 !== 1) begin
         tests_failed++; $display("FAIL minus5_valid: got %0d pulses want 1", vs - v0);
      end
      tests_run++;
      if (es - e0 !== 0) begin
         tests_failed++; $display("FAIL minus5_error: got %0d pulses want 0", es - e0);
      end
   endtask

   task automatic test_latency();
      int lat = 0;
      int v0;
      hold_s(2'b01, seg(10), 20);
      v0 = vs;
      bus_s.Indicators = 2'b10;
      bus_s.Segments   = seg(7);
      for (int n = 1; n <= 50 && lat == 0; n++) begin
         @(posedge clk);
         #1;
         if (bus_s.Valid) lat = n;
      end
      tests_run++;
      if (lat !== 7 + SyncLat) begin
         tests_failed++; $display("FAIL latency: got %0d clocks want %0d", lat, 7 + SyncLat);
      end
      tests_run++;
      if (bus_s.Data !== 4'h7) begin
         tests_failed++; $display("FAIL max_pos_data: got %h want 7", bus_s.Data);
      end
      repeat (20) @(negedge clk);
      tests_run++;
      if (vs - v0 !== 1) begin
         tests_failed++; $display("FAIL max_pos_valid: got %0d pulses want 1", vs - v0);
      end
   endtask

   task automatic test_range_signed();
      int v0 = vs, e0 = es;
      hold_s(2'b01, seg(10), 20);
      hold_s(2'b10, seg(9), 20);
      tests_run++;
      if (es - e0 !== 1 || vs - v0 !== 0) begin
         tests_failed++; $display("FAIL overrange: got err %0d val %0d want 1 0", es - e0, vs - v0);
      end
      tests_run++;
      if (bus_s.Data !== 4'h7) begin
         tests_failed++; $display("FAIL overrange_hold: got %h want 7", bus_s.Data);
      end
      hold_s(2'b01, seg(3), 20);
      hold_s(2'b10, seg(1), 20);
      tests_run++;
      if (es - e0 !== 2 || vs - v0 !== 0) begin
         tests_failed++; $display("FAIL digit_in_sign: got err %0d val %0d want 2 0", es - e0, vs - v0);
      end
      tests_run++;
      if (bus_s.Data !== 4'h7) begin
         tests_failed++; $display("FAIL digit_in_sign_hold: got %h want 7", bus_s.Data);
      end
   endtask

   task automatic test_glitch();
      int v0 = vs, e0 = es;
      hold_s(2'b01, seg(11), 20);
      hold_s(2'b10, seg(2), 3);
      hold_s(2'b11, seg(2), 20);
      hold_s(2'b00, seg(4), 20);
      tests_run++;
      if (vs - v0 !== 0 || es - e0 !== 0) begin
         tests_failed++; $display("FAIL glitch_pulse: got val %0d err %0d want 0 0", vs - v0, es - e0);
      end
      tests_run++;
      if (bus_s.Data !== 4'h7) begin
         tests_failed++; $display("FAIL glitch_data: got %h want 7", bus_s.Data);
      end
      hold_s(2'b10, seg(2), 20);
      tests_run++;
      if (vs - v0 !== 1) begin
         tests_failed++; $display("FAIL minus2_valid: got %0d pulses want 1", vs - v0);
      end
      tests_run++;
      if (bus_s.Data !== 4'hA) begin
         tests_failed++; $display("FAIL minus2_data: got %h want a", bus_s.Data);
      end
   endtask

   task automatic test_timeout();
      int v0 = vs, e0 = es;
      hold_s(2'b10, seg(6), 3000);
      hold_s(2'b01, seg(10), 20);
      tests_run++;
      if (vs - v0 !== 0 || es - e0 !== 0) begin
         tests_failed++; $display("FAIL timeout_pulse: got val %0d err %0d want 0 0", vs - v0, es - e0);
      end
      hold_s(2'b10, seg(4), 20);
      tests_run++;
      if (vs - v0 !== 1 || es - e0 !== 0) begin
         tests_failed++; $display("FAIL after_timeout: got val %0d err %0d want 1 0", vs - v0, es - e0);
      end
      tests_run++;
      if (bus_s.Data !== 4'h4) begin
         tests_failed++; $display("FAIL after_timeout_data: got %h want 4", bus_s.Data);
      end
   endtask

   task automatic test_unsigned();
      int v0 = vu, e0 = eu;
      hold_u(3'b011, seg(2), 20);
      hold_u(3'b101, seg(5), 20);
      hold_u(3'b110, seg(5), 20);
      tests_run++;
      if (vu - v0 !== 1 || bus_u.Data !== 8'hFF) begin
         tests_failed++; $display("FAIL u255: got val %0d data %h want 1 ff", vu - v0, bus_u.Data);
      end
      hold_u(3'b011, seg(3), 20);
      hold_u(3'b101, seg(0), 20);
      hold_u(3'b110, seg(0), 20);
      tests_run++;
      if (eu - e0 !== 1 || vu - v0 !== 1) begin
         tests_failed++; $display("FAIL u300: got err %0d val %0d want 1 1", eu - e0, vu - v0);
      end
      tests_run++;
      if (bus_u.Data !== 8'hFF) begin
         tests_failed++; $display("FAIL u300_hold: got %h want ff", bus_u.Data);
      end
      hold_u(3'b011, seg(0), 20);
      hold_u(3'b101, seg(11), 20);
      hold_u(3'b110, seg(1), 20);
      tests_run++;
      if (eu - e0 !== 2) begin
         tests_failed++; $display("FAIL u_minus_mag: got %0d errors want 2", eu - e0);
      end
      hold_u(3'b011, seg(10), 20);
      hold_u(3'b101, seg(10), 20);
      hold_u(3'b110, seg(7), 20);
      tests_run++;
      if (vu - v0 !== 2 || bus_u.Data !== 8'h07) begin
         tests_failed++; $display("FAIL u_blanks: got val %0d data %h want 2 07", vu - v0, bus_u.Data);
      end
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      hold_s(2'b01, seg(11), 20);
      v0 = vs;
      e0 = es;
      bus_s.Indicators = 2'b10;
      bus_s.Segments   = seg(1);
      repeat (6 + SyncLat) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus_s.Data !== 4'h0 || bus_s.Valid !== 1'b0 || bus_s.Error !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: got %h %b %b want 0 0 0", bus_s.Data, bus_s.Valid, bus_s.Error);
      end
      bus_s.Indicators = 2'b11;
      bus_s.Segments   = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      tests_run++;
      if (vs - v0 !== 0 || es - e0 !== 0) begin
         tests_failed++; $display("FAIL post_reset_quiet: got val %0d err %0d want 0 0", vs - v0, es - e0);
      end
      hold_s(2'b01, seg(10), 20);
      hold_s(2'b10, seg(2), 20);
      tests_run++;
      if (vs - v0 !== 1 || bus_s.Data !== 4'h2) begin
         tests_failed++; $display("FAIL post_reset_frame: got val %0d data %h want 1 2", vs - v0, bus_s.Data);
      end
   endtask

   task automatic test_exclusive();
      tests_run++;
      if (both !== 0) begin
         tests_failed++; $display("FAIL valid_error_overlap: got %0d cycles want 0", both);
      end
   endtask

   initial begin
      test_reset();
      test_signed_minus();
      test_latency();
      test_range_signed();
      test_glitch();
      test_timeout();
      test_unsigned();
      test_reset_mid();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
